// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - upstream, data-memory and writeback signals of the memory stage
interface mem_stage_if;
  // upstream instruction
  logic        in_valid;
  logic [3:0]  in_op;
  logic [31:0] in_rslt;
  logic [31:0] in_wdata;
  logic [4:0]  in_rd;
  logic        stall;
  // data memory request/acknowledge
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  // register writeback
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_err;

  // environment side: drives instructions and memory responses
  modport master (
    output in_valid, in_op, in_rslt, in_wdata, in_rd, mem_ack, mem_rdata,
    input  stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  wb_valid, wb_we, wb_rd, wb_data, wb_err
  );

  // stage side
  modport slave (
    input  in_valid, in_op, in_rslt, in_wdata, in_rd, mem_ack, mem_rdata,
    output stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output wb_valid, wb_we, wb_rd, wb_data, wb_err
  );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage; MEM_STAGE_SUBWORD_EN enables byte/halfword ops
module mem_stage (
  input  logic      clk,
  input  logic      rst,
  mem_stage_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LW   = 4'd1;
  localparam logic [3:0] OP_SW   = 4'd2;
`ifdef MEM_STAGE_SUBWORD_EN
  localparam logic [3:0] OP_LB   = 4'd3;
  localparam logic [3:0] OP_LBU  = 4'd4;
  localparam logic [3:0] OP_LH   = 4'd5;
  localparam logic [3:0] OP_LHU  = 4'd6;
  localparam logic [3:0] OP_SB   = 4'd7;
  localparam logic [3:0] OP_SH   = 4'd8;
`endif

  state_t      state_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_wdata_q;
  logic        store_q;
  logic [4:0]  rd_q;
  logic        wb_valid_q;
  logic        wb_we_q;
  logic        wb_err_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
`ifdef MEM_STAGE_SUBWORD_EN
  logic [3:0]  op_q;
  logic [1:0]  lane_q;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
`endif

  logic        is_none;
  logic        is_store;
  logic        mem_ok;
  logic [3:0]  req_be_d;
  logic [31:0] req_wdata_d;
  logic [31:0] load_data;

  // Decode the incoming op: legality, alignment, byte enables and lane-aligned store data
  always_comb begin
    is_none     = (bus.in_op == OP_NONE);
    is_store    = 1'b0;
    mem_ok      = 1'b0;
    req_be_d    = 4'b1111;
    req_wdata_d = bus.in_wdata;
    case (bus.in_op)
      OP_LW: mem_ok = (bus.in_rslt[1:0] == 2'b00);
      OP_SW: begin
        is_store = 1'b1;
        mem_ok   = (bus.in_rslt[1:0] == 2'b00);
      end
`ifdef MEM_STAGE_SUBWORD_EN
      OP_LB, OP_LBU, OP_SB: begin
        is_store    = (bus.in_op == OP_SB);
        mem_ok      = 1'b1;
        req_be_d    = 4'b0001 << bus.in_rslt[1:0];
        req_wdata_d = {4{bus.in_wdata[7:0]}};
      end
      OP_LH, OP_LHU, OP_SH: begin
        is_store    = (bus.in_op == OP_SH);
        mem_ok      = !bus.in_rslt[0];
        req_be_d    = 4'b0011 << bus.in_rslt[1:0];
        req_wdata_d = {2{bus.in_wdata[15:0]}};
      end
`endif
      default: mem_ok = 1'b0;
    endcase
  end

  // Select and extend the addressed lane of the returned read word
  always_comb begin
    load_data = bus.mem_rdata;
`ifdef MEM_STAGE_SUBWORD_EN
    case (lane_q)
      2'd0:    byte_sel = bus.mem_rdata[7:0];
      2'd1:    byte_sel = bus.mem_rdata[15:8];
      2'd2:    byte_sel = bus.mem_rdata[23:16];
      default: byte_sel = bus.mem_rdata[31:24];
    endcase
    half_sel = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (op_q)
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {24'd0, byte_sel};
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {16'd0, half_sel};
      default: load_data = bus.mem_rdata;
    endcase
`endif
  end

  // Stage control: accept in IDLE, hold the request in BUSY until ack, retire one pulse per instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      store_q     <= 1'b0;
      rd_q        <= 5'd0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_err_q    <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= 32'd0;
`ifdef MEM_STAGE_SUBWORD_EN
      op_q        <= 4'd0;
      lane_q      <= 2'd0;
`endif
    end else begin
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            if (is_none) begin
              wb_valid_q <= 1'b1;
              wb_we_q    <= (bus.in_rd != 5'd0);
              wb_rd_q    <= bus.in_rd;
              wb_data_q  <= bus.in_rslt;
            end else if (mem_ok) begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store;
              mem_addr_q  <= {bus.in_rslt[31:2], 2'b00};
              mem_be_q    <= req_be_d;
              mem_wdata_q <= req_wdata_d;
              store_q     <= is_store;
              rd_q        <= bus.in_rd;
`ifdef MEM_STAGE_SUBWORD_EN
              op_q        <= bus.in_op;
              lane_q      <= bus.in_rslt[1:0];
`endif
              state_q     <= BUSY;
            end else begin
              // misaligned or illegal: retire immediately with an error, no memory traffic
              wb_valid_q <= 1'b1;
              wb_err_q   <= 1'b1;
              wb_rd_q    <= bus.in_rd;
              wb_data_q  <= 32'd0;
            end
          end
        end
        BUSY: begin
          if (bus.mem_ack) begin
            mem_req_q  <= 1'b0;
            wb_valid_q <= 1'b1;
            wb_rd_q    <= rd_q;
            wb_we_q    <= !store_q && (rd_q != 5'd0);
            wb_data_q  <= store_q ? 32'd0 : load_data;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.stall     = ((state_q == IDLE) && bus.in_valid && !is_none && mem_ok) ||
                         ((state_q == BUSY) && !bus.mem_ack);
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_we     = wb_we_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.wb_err    = wb_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mem_stage_if bus ();

  mem_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [3:0] op, input logic [31:0] rslt, input logic [31:0] wdata,
                         input logic [4:0] rd);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rslt  = rslt;
    bus.in_wdata = wdata;
    bus.in_rd    = rd;
  endtask

  // NONE, misaligned or illegal op: retire one cycle later without stalling or touching memory
  task automatic one_cycle(input string tag, input logic [3:0] op, input logic [31:0] rslt,
                           input logic [4:0] rd, input logic exp_err, input logic exp_we,
                           input logic [31:0] exp_data);
    present(op, rslt, 32'h5555_AAAA, rd);
    #1;
    check({tag, ".stall"}, {31'd0, bus.stall}, 32'd0);
    tick();
    bus.in_valid = 1'b0;
    check({tag, ".wb_valid"}, {31'd0, bus.wb_valid}, 32'd1);
    check({tag, ".wb_err"}, {31'd0, bus.wb_err}, {31'd0, exp_err});
    check({tag, ".wb_we"}, {31'd0, bus.wb_we}, {31'd0, exp_we});
    check({tag, ".wb_data"}, bus.wb_data, exp_data);
    check({tag, ".wb_rd"}, {27'd0, bus.wb_rd}, {27'd0, rd});
    check({tag, ".mem_req"}, {31'd0, bus.mem_req}, 32'd0);
  endtask

  // Memory op accepted at t, ack driven in cycle t+k, writeback checked in cycle t+k+1
  task automatic mem_txn(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd, input int k,
                         input logic [31:0] rdata, input logic exp_we, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_wb,
                         input logic exp_wbwe);
    present(op, addr, wdata, rd);
    #1;
    check({tag, ".stall_acc"}, {31'd0, bus.stall}, 32'd1);
    tick();
    check({tag, ".mem_req"}, {31'd0, bus.mem_req}, 32'd1);
    check({tag, ".mem_we"}, {31'd0, bus.mem_we}, {31'd0, exp_we});
    check({tag, ".mem_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
    check({tag, ".mem_be"}, {28'd0, bus.mem_be}, {28'd0, exp_be});
    if (exp_we) check({tag, ".mem_wdata"}, bus.mem_wdata, exp_wdata);
    for (int i = 1; i < k; i++) begin
      check({tag, ".stall_busy"}, {31'd0, bus.stall}, 32'd1);
      check({tag, ".req_held"}, {31'd0, bus.mem_req}, 32'd1);
      tick();
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rdata;
    #1;
    check({tag, ".stall_ack"}, {31'd0, bus.stall}, 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;
    check({tag, ".req_drop"}, {31'd0, bus.mem_req}, 32'd0);
    check({tag, ".wb_valid"}, {31'd0, bus.wb_valid}, 32'd1);
    check({tag, ".wb_err"}, {31'd0, bus.wb_err}, 32'd0);
    check({tag, ".wb_we"}, {31'd0, bus.wb_we}, {31'd0, exp_wbwe});
    check({tag, ".wb_data"}, bus.wb_data, exp_wb);
    check({tag, ".wb_rd"}, {27'd0, bus.wb_rd}, {27'd0, rd});
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;
    present(4'd1, 32'h0000_0100, 32'd0, 5'd5);

    // reset held with a valid LW on the inputs
    repeat (3) tick();
    check("rst.mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst.mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst.mem_addr", bus.mem_addr, 32'd0);
    check("rst.mem_be", {28'd0, bus.mem_be}, 32'd0);
    check("rst.mem_wdata", bus.mem_wdata, 32'd0);
    check("rst.wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("rst.wb_we", {31'd0, bus.wb_we}, 32'd0);
    check("rst.wb_rd", {27'd0, bus.wb_rd}, 32'd0);
    check("rst.wb_data", bus.wb_data, 32'd0);
    check("rst.wb_err", {31'd0, bus.wb_err}, 32'd0);
    rst = 1'b0;

    // first accept right after reset; ack three cycles after mem_req rises
    mem_txn("lw", 4'd1, 32'h0000_0100, 32'd0, 5'd5, 4, 32'hDEAD_BEEF,
            1'b0, 4'hF, 32'd0, 32'hDEAD_BEEF, 1'b1);
    // back-to-back into the retire cycle
    one_cycle("none", 4'd0, 32'h0000_1234, 5'd3, 1'b0, 1'b1, 32'h0000_1234);
    one_cycle("none_r0", 4'd0, 32'hCAFE_0001, 5'd0, 1'b0, 1'b0, 32'hCAFE_0001);
    tick();
    check("pulse.wb_valid", {31'd0, bus.wb_valid}, 32'd0);

    one_cycle("sw_mis", 4'd2, 32'h0000_0102, 5'd7, 1'b1, 1'b0, 32'd0);
    one_cycle("lw_mis", 4'd1, 32'h0000_0101, 5'd7, 1'b1, 1'b0, 32'd0);
    one_cycle("illegal", 4'd9, 32'h0000_0100, 5'd8, 1'b1, 1'b0, 32'd0);
    one_cycle("lh_bad", 4'd5, 32'h0000_0101, 5'd8, 1'b1, 1'b0, 32'd0);
    mem_txn("sw", 4'd2, 32'h0000_0200, 32'h1122_3344, 5'd9, 1, 32'hFFFF_FFFF,
            1'b1, 4'hF, 32'h1122_3344, 32'd0, 1'b0);
    mem_txn("lw_r0", 4'd1, 32'h0000_0040, 32'd0, 5'd0, 2, 32'h0BAD_F00D,
            1'b0, 4'hF, 32'd0, 32'h0BAD_F00D, 1'b0);

`ifdef MEM_STAGE_SUBWORD_EN
    mem_txn("lb", 4'd3, 32'h0000_0103, 32'd0, 5'd4, 2, 32'h8000_0000,
            1'b0, 4'b1000, 32'd0, 32'hFFFF_FF80, 1'b1);
    mem_txn("sh", 4'd8, 32'h0000_0202, 32'h0000_ABCD, 5'd4, 1, 32'd0,
            1'b1, 4'b1100, 32'hABCD_ABCD, 32'd0, 1'b0);
    mem_txn("lhu", 4'd6, 32'h0000_0202, 32'd0, 5'd6, 1, 32'h8001_1234,
            1'b0, 4'b1100, 32'd0, 32'h0000_8001, 1'b1);
    mem_txn("lh", 4'd5, 32'h0000_0200, 32'd0, 5'd6, 1, 32'h0000_F00F,
            1'b0, 4'b0011, 32'd0, 32'hFFFF_F00F, 1'b1);
    mem_txn("lbu", 4'd4, 32'h0000_0101, 32'd0, 5'd2, 3, 32'h0000_AB00,
            1'b0, 4'b0010, 32'd0, 32'h0000_00AB, 1'b1);
    mem_txn("sb", 4'd7, 32'h0000_0301, 32'h0000_005A, 5'd2, 1, 32'd0,
            1'b1, 4'b0010, 32'h5A5A_5A5A, 32'd0, 1'b0);
`else
    one_cycle("lb_off", 4'd3, 32'h0000_0103, 5'd4, 1'b1, 1'b0, 32'd0);
    one_cycle("sh_off", 4'd8, 32'h0000_0202, 5'd4, 1'b1, 1'b0, 32'd0);
    one_cycle("lbu_off", 4'd4, 32'h0000_0100, 5'd2, 1'b1, 1'b0, 32'd0);
`endif

    // stray ack while idle is ignored
    bus.in_valid = 1'b0;
    bus.mem_ack  = 1'b1;
    tick();
    check("stray.mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("stray.wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    bus.mem_ack = 1'b0;

    // reset while BUSY, then a late ack
    present(4'd1, 32'h0000_0300, 32'd0, 5'd11);
    tick();
    check("rbusy.mem_req", {31'd0, bus.mem_req}, 32'd1);
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rbusy.req_after_rst", {31'd0, bus.mem_req}, 32'd0);
    check("rbusy.wb_after_rst", {31'd0, bus.wb_valid}, 32'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    #1;
    check("rbusy.stall_late", {31'd0, bus.stall}, 32'd0);
    tick();
    bus.mem_ack = 1'b0;
    check("rbusy.late_wb", {31'd0, bus.wb_valid}, 32'd0);
    check("rbusy.late_req", {31'd0, bus.mem_req}, 32'd0);
    one_cycle("after_rst", 4'd0, 32'h0000_00FE, 5'd1, 1'b0, 1'b1, 32'h0000_00FE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
